// File: rtl/opc_waitstate_ctrl.sv
// opc_waitstate_ctrl: bus wait-state controller for the OPC CPU; stalls clken per region (memory, slow window, IO) and drives active-low strobes.
// Latency: an access with wait N holds clken low for N cycles, then high for one completion cycle (N+1 total); zero-wait accesses complete at once.
// Backpressure: clken is the only stall mechanism; withdrawing the request mid-wait aborts the access. Optional statistics under `OPC_WAIT_STATS_EN.
module opc_waitstate_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                WAIT_W    = 4,
  parameter int                MEM_WAIT  = 1,
  parameter int                SLOW_WAIT = 3,
  parameter int                IO_WAIT   = 2,
  parameter logic [ADDR_W-1:0] SLOW_BASE = 16'hF000,
  parameter logic [ADDR_W-1:0] SLOW_MASK = 16'hF000
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              vpa,
  input  logic              vda,
  input  logic              vio,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] address,
  output logic              clken,
  output logic              mem_ce_b,
  output logic              io_ce_b,
  output logic              oe_b,
  output logic              we_b,
  output logic              busy,
  output logic [15:0]       stall_count,
  output logic [15:0]       access_count
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [WAIT_W-1:0] W_MEM  = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] W_SLOW = WAIT_W'(SLOW_WAIT);
  localparam logic [WAIT_W-1:0] W_IO   = WAIT_W'(IO_WAIT);
  localparam logic [WAIT_W-1:0] W_ONE  = WAIT_W'(1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic [WAIT_W-1:0] sel_wait;
  logic              req;
  logic              in_slow;
  logic              clken_fsm;

  assign req     = vpa | vda | vio;
  assign in_slow = (address & SLOW_MASK) == SLOW_BASE;

  // Region wait count; only consulted in IDLE, so the region is fixed at access start.
  always_comb begin
    sel_wait = W_MEM;
    if (vio)
      sel_wait = W_IO;
    else if (in_slow)
      sel_wait = W_SLOW;
  end

  // State and remaining-wait counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and stall strobe; a withdrawn request in WAIT aborts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clken_fsm = 1'b1;
    case (state)
      ST_IDLE: begin
        if (req && (sel_wait != '0)) begin
          clken_fsm = 1'b0;
          cnt_nxt   = sel_wait - W_ONE;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          clken_fsm = 1'b0;
          cnt_nxt   = cnt - W_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset forces the CPU running and all strobes inactive regardless of the bus.
  assign clken    = ~reset_b | clken_fsm;
  assign mem_ce_b = ~(reset_b & (vpa | vda) & ~vio);
  assign io_ce_b  = ~(reset_b & vio);
  assign oe_b     = ~(reset_b & req & rnw);
  assign we_b     = ~(reset_b & req & ~rnw & clken);
  assign busy     = (state == ST_WAIT);

`ifdef OPC_WAIT_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] access_q;

  // Saturating stall-cycle and completed-access counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      stall_q  <= '0;
      access_q <= '0;
    end else begin
      if (!clken && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (req && clken && (access_q != 16'hFFFF))
        access_q <= access_q + 16'd1;
    end
  end

  assign stall_count  = stall_q;
  assign access_count = access_q;
`else
  assign stall_count  = '0;
  assign access_count = '0;
`endif

endmodule

// File: doc/opc_waitstate_ctrl.md
Name: opc_waitstate_ctrl

Overview:
- Synthesisable bus wait-state controller for the OPC CPU family; sits between the CPU bus outputs (vpa/vda/vio/rnw/address) and external memory/IO.
- Generates the CPU clken stall strobe with independently parametrised wait counts for program/data memory, a decodable slow-memory window and IO space.
- Drives active-low chip-enable, output-enable and write strobes.
- Generalises the fixed one-wait-state memory handshake used by the current bench into a configurable, per-region block.

Parameters:
- ADDR_W, 16, address bus width.
- WAIT_W, 4, width of the wait-state counter; all wait parameters must be less than 2**WAIT_W.
- MEM_WAIT, 1, stall cycles for memory accesses outside the slow window.
- SLOW_WAIT, 3, stall cycles for memory accesses inside the slow window.
- IO_WAIT, 2, stall cycles for IO accesses.
- SLOW_BASE, 16'hF000, slow window match value.
- SLOW_MASK, 16'hF000, slow window mask; the address is in the window when (address & SLOW_MASK) == SLOW_BASE.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- vpa  in  1  CPU valid program address.
- vda  in  1  CPU valid data address.
- vio  in  1  CPU IO access qualifier.
- rnw  in  1  CPU read/not-write.
- address  in  ADDR_W  CPU address.
- clken  out  1  CPU clock enable; 0 stalls the CPU.
- mem_ce_b  out  1  memory chip enable, active low.
- io_ce_b  out  1  IO chip enable, active low.
- oe_b  out  1  output enable, active low.
- we_b  out  1  write strobe, active low.
- busy  out  1  high while in the WAIT state.
- stall_count  out  16  stall-cycle statistic (see Optional Feature).
- access_count  out  16  completed-access statistic (see Optional Feature).

Behaviour:
- Definitions:
  - req = vpa | vda | vio.
  - sel_wait:
    - IO_WAIT if vio = 1;
    - else SLOW_WAIT if address is in the slow window;
    - else MEM_WAIT.
  - sel_wait is evaluated combinationally in IDLE only.
- Reset (async, reset_b low):
  - state = IDLE, cnt = 0, busy = 0, clken = 1.
  - mem_ce_b = io_ce_b = oe_b = we_b = 1 (forced inactive while reset_b is low).
  - Both statistics counters = 0.
- FSM states: IDLE, WAIT.
  - IDLE, req = 0: clken = 1, stay in IDLE.
  - IDLE, req = 1 and sel_wait = 0: clken = 1, stay in IDLE (zero-wait access).
  - IDLE, req = 1 and sel_wait > 0: clken = 0, cnt <= sel_wait - 1, go to WAIT.
  - WAIT, cnt = 0: clken = 1, go to IDLE.
  - WAIT, cnt != 0: clken = 0, cnt <= cnt - 1.
  - WAIT, req = 0 (access withdrawn): clken = 1, go to IDLE next edge. This is an abort: no write strobe, not counted as an access.
- Latency: an access with wait N takes N+1 cycles. clken is low for N consecutive cycles, then high for exactly one completion cycle.
- Back-to-back accesses: after a completion cycle, IDLE re-evaluates the new address on the next cycle with no dead cycle. Example: MEM_WAIT = 1 gives the clken pattern 0,1,0,1.
- clken is combinational from state, cnt and req; busy is registered state == WAIT.
- Strobes (combinational, outside reset):
  - mem_ce_b = !((vpa | vda) & !vio).
  - io_ce_b = !vio.
  - oe_b = !(req & rnw).
  - we_b = !(req & !rnw & clken): asserted only in the completion cycle, exactly one cycle per write.
- The region is decided at access start. An address change during WAIT does not alter the remaining count.
- Reset mid-WAIT: immediate return to IDLE with clken = 1; the pending access is discarded.

Optional Feature:
- Macro: OPC_WAIT_STATS_EN.
- Defined:
  - stall_count increments on every cycle with clken = 0 and reset_b high.
  - access_count increments on every completion cycle (req = 1 and clken = 1). Aborts are not counted.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset: hold reset_b low, toggle inputs -> clken = 1, all strobes = 1, busy = 0; release reset_b -> IDLE.
- Memory read loop, MEM_WAIT = 1, vpa = 1, rnw = 1, address = 16'h0100 held -> clken 0,1,0,1...; mem_ce_b = 0, oe_b = 0, we_b = 1 throughout.
- Slow-window write, address = 16'hF004, vda = 1, rnw = 0, SLOW_WAIT = 3 -> clken 0,0,0,1; we_b low only on the 4th cycle; busy high on cycles 2-4.
- IO write, vio = 1, vda = 1, address = 16'hFE08, IO_WAIT = 2 -> io_ce_b = 0, mem_ce_b = 1, clken 0,0,1; override with MEM_WAIT = 0 -> memory accesses give clken constantly 1.
- Abort and reset: deassert req after 1 stall cycle of a SLOW access -> next cycle clken = 1, IDLE, no we_b pulse; assert reset_b low mid-WAIT -> clken = 1 asynchronously.
- OPC_WAIT_STATS_EN defined: 10 MEM_WAIT = 1 reads plus 1 abort -> access_count = 10, stall_count = 11. Preload near saturation (or force) -> holds at 16'hFFFF. Macro undefined -> both read 0.
